// File: rtl/sm3_ss_pipe_if.sv
// ---------------------------------------------------------------------------
// sm3_ss_pipe_if
// Bundles the handshake and data signals of the SM3 SS1/SS2 pipeline.
//   clear            : synchronous round-counter reset (start of a new block)
//   in_valid/in_ready: upstream handshake carrying state words a, e
//   out_valid/out_ready: downstream handshake carrying ss1, ss2, round, last
// Modports:
//   master : the side that feeds a/e and consumes results
//   slave  : the pipeline itself
// ---------------------------------------------------------------------------
interface sm3_ss_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int ROUNDS = 64
);
    localparam int RW = $clog2(ROUNDS);

    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] e;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ss1;
    logic [WIDTH-1:0] ss2;
    logic [RW-1:0]    round;
    logic             last;

    modport master (
        output clear, in_valid, a, e, out_ready,
        input  in_ready, out_valid, ss1, ss2, round, last
    );

    modport slave (
        input  clear, in_valid, a, e, out_ready,
        output in_ready, out_valid, ss1, ss2, round, last
    );
endinterface

// File: rtl/sm3_ss_pipe.sv
// ---------------------------------------------------------------------------
// sm3_ss_pipe
// Two-stage pipelined generator of the SM3 round intermediates
//   SS1 = ((A <<< ROT_A) + E + (Tj <<< (j mod WIDTH))) <<< ROT_S
//   SS2 = SS1 ^ (A <<< ROT_A)
// with an internal round counter j selecting Tj, and valid/ready flow control.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : sm3_ss_pipe_if.slave
//           clear, in_valid/in_ready, a, e       (input side)
//           out_valid/out_ready, ss1, ss2, round, last (output side)
// ---------------------------------------------------------------------------
module sm3_ss_pipe #(
    parameter int               WIDTH    = 32,
    parameter int               ROT_A    = 12,
    parameter int               ROT_S    = 7,
    parameter int               ROUNDS   = 64,
    parameter int               TJ_SPLIT = 16,
    parameter logic [WIDTH-1:0] TJ_LO    = 32'h79CC4519,
    parameter logic [WIDTH-1:0] TJ_HI    = 32'h7A879D8A
) (
    input  logic         clk,
    input  logic         rst_n,
    sm3_ss_pipe_if.slave bus
);
    localparam int            RW     = $clog2(ROUNDS);
    localparam logic [RW-1:0] LAST_J = RW'(ROUNDS - 1);

    // Left rotate; the amount is reduced mod WIDTH so 0 and WIDTH both mean
    // "no rotation". The upper half of {x,x} shifted left is the rotation.
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x,
                                              input int unsigned       sh);
        logic [2*WIDTH-1:0] dbl;
        dbl = {x, x} << (sh % WIDTH);
        return dbl[2*WIDTH-1:WIDTH];
    endfunction

    // Round counter
    logic [RW-1:0]    j_q, j_d;

    // Stage 1 registers
    logic             vld_p1_q, vld_p1_d;
    logic [WIDTH-1:0] r_p1_q, r_p1_d;
    logic [WIDTH-1:0] sum_p1_q, sum_p1_d;
    logic [RW-1:0]    j_p1_q, j_p1_d;

    // Stage 2 registers (drive the outputs directly)
    logic             vld_p2_q, vld_p2_d;
    logic [WIDTH-1:0] ss1_p2_q, ss1_p2_d;
    logic [WIDTH-1:0] ss2_p2_q, ss2_p2_d;
    logic [RW-1:0]    round_p2_q, round_p2_d;
    logic             last_p2_q, last_p2_d;

    logic             s2_free;
    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] tj_sel;
    logic [WIDTH-1:0] r_in;
    logic [WIDTH-1:0] ss1_in;

    // Stage 2 can take new data when empty or when its result leaves this
    // cycle; in_ready therefore depends on out_ready but never on in_valid.
    always_comb begin
        s2_free  = !vld_p2_q || bus.out_ready;
        in_ready = !vld_p1_q || s2_free;
        accept   = bus.in_valid && in_ready;
    end

    // Round counter: clear wins over the increment, but the accepted word
    // still uses the pre-clear j (captured in stage 1 below).
    always_comb begin
        j_d = j_q;
        if (bus.clear) begin
            j_d = '0;
        end else if (accept) begin
            j_d = (j_q == LAST_J) ? '0 : j_q + 1'b1;
        end
    end

    // ---- stage 0 -> stage 1 boundary ----
    always_comb begin
        tj_sel   = (int'(j_q) < TJ_SPLIT) ? TJ_LO : TJ_HI;
        r_in     = rotl(bus.a, ROT_A);
        vld_p1_d = vld_p1_q;
        r_p1_d   = r_p1_q;
        sum_p1_d = sum_p1_q;
        j_p1_d   = j_p1_q;
        if (accept) begin
            vld_p1_d = 1'b1;
            r_p1_d   = r_in;
            sum_p1_d = r_in + bus.e + rotl(tj_sel, 32'(j_q));
            j_p1_d   = j_q;
        end else if (s2_free) begin
            // Whatever stage 1 held has moved on (or it was already empty).
            vld_p1_d = 1'b0;
        end
    end

    // ---- stage 1 -> stage 2 boundary ----
    always_comb begin
        ss1_in     = rotl(sum_p1_q, ROT_S);
        vld_p2_d   = vld_p2_q;
        ss1_p2_d   = ss1_p2_q;
        ss2_p2_d   = ss2_p2_q;
        round_p2_d = round_p2_q;
        last_p2_d  = last_p2_q;
        if (s2_free) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                ss1_p2_d   = ss1_in;
                ss2_p2_d   = ss1_in ^ r_p1_q;
                round_p2_d = j_p1_q;
                last_p2_d  = (j_p1_q == LAST_J);
            end
        end
    end

    // Control state and the visible output registers are reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j_q        <= '0;
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            ss1_p2_q   <= '0;
            ss2_p2_q   <= '0;
            round_p2_q <= '0;
            last_p2_q  <= 1'b0;
        end else begin
            j_q        <= j_d;
            vld_p1_q   <= vld_p1_d;
            vld_p2_q   <= vld_p2_d;
            ss1_p2_q   <= ss1_p2_d;
            ss2_p2_q   <= ss2_p2_d;
            round_p2_q <= round_p2_d;
            last_p2_q  <= last_p2_d;
        end
    end

    // Stage 1 data is only meaningful alongside vld_p1_q, so it is not reset.
    always_ff @(posedge clk) begin
        r_p1_q   <= r_p1_d;
        sum_p1_q <= sum_p1_d;
        j_p1_q   <= j_p1_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_p2_q;
    assign bus.ss1       = ss1_p2_q;
    assign bus.ss2       = ss2_p2_q;
    assign bus.round     = round_p2_q;
    assign bus.last      = last_p2_q;

endmodule
